// File: rtl/cr_clint_tcipif_arb.sv
// Two-requester arbiter in front of the single CLINT tcipif slave port.
// m0 = core load/store path, m1 = debug/system-bus path. The winning request
// is registered, issued to the CLINT as a one-cycle select, and the CLINT
// completion (or a watchdog timeout) is returned only to the granted requester.
module cr_clint_tcipif_arb #(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned TO_CNT_W    = 16
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        m0_clint_req,
    input  logic [15:0] m0_clint_addr,
    input  logic        m0_clint_write,
    input  logic [31:0] m0_clint_wdata,
    output logic        m0_clint_cmplt,
    output logic [31:0] m0_clint_rdata,
    output logic        m0_clint_err,
    input  logic        m1_clint_req,
    input  logic [15:0] m1_clint_addr,
    input  logic        m1_clint_write,
    input  logic [31:0] m1_clint_wdata,
    output logic        m1_clint_cmplt,
    output logic [31:0] m1_clint_rdata,
    output logic        m1_clint_err,
    output logic        tcipif_clint_sel,
    output logic [15:0] tcipif_clint_addr,
    output logic        tcipif_clint_write,
    output logic [31:0] tcipif_clint_wdata,
    input  logic        clint_tcipif_cmplt,
    input  logic [31:0] clint_tcipif_rdata,
    output logic        arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rr_ptr;
    logic                r_grant_id;
    logic [15:0]         r_addr;
    logic                r_write;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [TO_CNT_W-1:0] r_to_cnt;
    logic                w_any_req;
    logic                w_pick;
    logic                w_timeout;

    // Winner: a lone requester always wins; on contention rr_ptr decides.
    assign w_any_req = m0_clint_req | m1_clint_req;
    assign w_pick    = m1_clint_req & (~m0_clint_req | r_rr_ptr);
    assign w_timeout = (r_to_cnt == TO_LAST);

    // State register.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; a completion always beats a simultaneous timeout.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = clint_tcipif_cmplt ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (clint_tcipif_cmplt || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Payload capture, response capture, watchdog counter and round-robin pointer.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_rr_ptr   <= 1'b0;
            r_grant_id <= 1'b0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_id <= w_pick;
                        r_addr     <= w_pick ? m1_clint_addr  : m0_clint_addr;
                        r_write    <= w_pick ? m1_clint_write : m0_clint_write;
                        r_wdata    <= w_pick ? m1_clint_wdata : m0_clint_wdata;
                    end
                end
                ST_ISSUE: begin
                    r_to_cnt <= '0;
                    if (clint_tcipif_cmplt) begin
                        r_rdata <= clint_tcipif_rdata;
                        r_err   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (clint_tcipif_cmplt) begin
                        r_rdata <= clint_tcipif_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_RESP: r_rr_ptr <= ~r_grant_id;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; the non-granted requester sees all zeros.
    always_comb begin
        tcipif_clint_sel   = (r_state == ST_ISSUE);
        tcipif_clint_addr  = r_addr;
        tcipif_clint_write = r_write;
        tcipif_clint_wdata = r_wdata;
        arb_busy           = (r_state != ST_IDLE);
        m0_clint_cmplt     = (r_state == ST_RESP) && !r_grant_id;
        m1_clint_cmplt     = (r_state == ST_RESP) &&  r_grant_id;
        m0_clint_rdata     = m0_clint_cmplt ? r_rdata : '0;
        m1_clint_rdata     = m1_clint_cmplt ? r_rdata : '0;
        m0_clint_err       = m0_clint_cmplt & r_err;
        m1_clint_err       = m1_clint_cmplt & r_err;
    end

endmodule

// File: tb/tb_cr_clint_tcipif_arb.sv
// Directed bench for cr_clint_tcipif_arb with a 4-cycle watchdog.
module tb_cr_clint_tcipif_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_write, m0_cmplt, m0_err;
    logic [15:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_write, m1_cmplt, m1_err;
    logic [15:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        sel, t_write, c_cmplt, busy;
    logic [15:0] t_addr;
    logic [31:0] t_wdata, c_rdata;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    cr_clint_tcipif_arb #(.TIMEOUT_CYC(4), .TO_CNT_W(16)) u_dut (
        .forever_cpuclk     (clk),
        .cpurst             (rst),
        .m0_clint_req       (m0_req),
        .m0_clint_addr      (m0_addr),
        .m0_clint_write     (m0_write),
        .m0_clint_wdata     (m0_wdata),
        .m0_clint_cmplt     (m0_cmplt),
        .m0_clint_rdata     (m0_rdata),
        .m0_clint_err       (m0_err),
        .m1_clint_req       (m1_req),
        .m1_clint_addr      (m1_addr),
        .m1_clint_write     (m1_write),
        .m1_clint_wdata     (m1_wdata),
        .m1_clint_cmplt     (m1_cmplt),
        .m1_clint_rdata     (m1_rdata),
        .m1_clint_err       (m1_err),
        .tcipif_clint_sel   (sel),
        .tcipif_clint_addr  (t_addr),
        .tcipif_clint_write (t_write),
        .tcipif_clint_wdata (t_wdata),
        .clint_tcipif_cmplt (c_cmplt),
        .clint_tcipif_rdata (c_rdata),
        .arb_busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response outputs of both requesters in one go.
    task automatic chk_resp(input string tag, input logic c0, input logic [31:0] d0,
                            input logic e0, input logic c1, input logic [31:0] d1,
                            input logic e1);
        chk({tag, ".m0_cmplt"}, {31'd0, m0_cmplt}, {31'd0, c0});
        chk({tag, ".m0_rdata"}, m0_rdata, d0);
        chk({tag, ".m0_err"},   {31'd0, m0_err},   {31'd0, e0});
        chk({tag, ".m1_cmplt"}, {31'd0, m1_cmplt}, {31'd0, c1});
        chk({tag, ".m1_rdata"}, m1_rdata, d1);
        chk({tag, ".m1_err"},   {31'd0, m1_err},   {31'd0, e1});
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] a, input logic w,
                             input logic [31:0] d);
        chk({tag, ".sel"},   {31'd0, sel},     32'd1);
        chk({tag, ".addr"},  {16'd0, t_addr},  {16'd0, a});
        chk({tag, ".write"}, {31'd0, t_write}, {31'd0, w});
        chk({tag, ".wdata"}, t_wdata, d);
        chk({tag, ".busy"},  {31'd0, busy},    32'd1);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_addr = '0; m0_write = 0; m0_wdata = '0;
        m1_req = 0; m1_addr = '0; m1_write = 0; m1_wdata = '0;
        c_cmplt = 0; c_rdata = '0;
        tick(); tick();
        chk("rst.sel",  {31'd0, sel},  32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.addr", {16'd0, t_addr}, 32'd0);
        chk("rst.wdata", t_wdata, 32'd0);
        chk_resp("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // m0 only, CLINT completes 2 cycles after sel.
        m0_req = 1; m0_addr = 16'h4000; m0_write = 1; m0_wdata = 32'h1;
        tick();
        chk_issue("t1.issue", 16'h4000, 1'b1, 32'h1);
        tick();
        chk("t1.w0.sel",  {31'd0, sel}, 32'd0);
        chk("t1.w0.addr", {16'd0, t_addr}, 32'h4000);
        tick();
        c_cmplt = 1; c_rdata = 32'h1234_5678;
        tick();
        c_cmplt = 0; c_rdata = '0; m0_req = 0;
        chk_resp("t1.resp", 1, 32'h1234_5678, 0, 0, 0, 0);
        chk("t1.resp.sel", {31'd0, sel}, 32'd0);
        tick();
        chk("t1.idle.busy", {31'd0, busy}, 32'd0);
        chk_resp("t1.idle", 0, 0, 0, 0, 0, 0);

        // Zero-latency slave on m1.
        m1_req = 1; m1_addr = 16'h0008; m1_write = 0; m1_wdata = 32'h55;
        tick();
        chk_issue("t3.issue", 16'h0008, 1'b0, 32'h55);
        c_cmplt = 1; c_rdata = 32'hDEAD_BEEF;
        tick();
        c_cmplt = 0; c_rdata = '0; m1_req = 0;
        chk_resp("t3.resp", 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        tick();
        chk("t3.idle.busy", {31'd0, busy}, 32'd0);

        // Both requesting continuously: m0, m1, m0, m1.
        m0_req = 1; m0_addr = 16'h1000; m0_write = 1; m0_wdata = 32'hA0;
        m1_req = 1; m1_addr = 16'h2000; m1_write = 0; m1_wdata = 32'hB1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k % 2 == 0) chk_issue($sformatf("t2.%0d", k), 16'h1000, 1'b1, 32'hA0);
            else            chk_issue($sformatf("t2.%0d", k), 16'h2000, 1'b0, 32'hB1);
            tick();
            chk($sformatf("t2.%0d.wait.sel", k), {31'd0, sel}, 32'd0);
            c_cmplt = 1; c_rdata = 32'hC000_0000 + k;
            tick();
            c_cmplt = 0; c_rdata = '0;
            if (k % 2 == 0) chk_resp($sformatf("t2.%0d", k), 1, 32'hC000_0000 + k, 0, 0, 0, 0);
            else            chk_resp($sformatf("t2.%0d", k), 0, 0, 0, 1, 32'hC000_0000 + k, 0);
            tick();
            chk($sformatf("t2.%0d.idle.busy", k), {31'd0, busy}, 32'd0);
            chk($sformatf("t2.%0d.idle.sel", k),  {31'd0, sel},  32'd0);
        end
        m0_req = 0; m1_req = 0;

        // Timeout on m0, then a late completion in IDLE.
        m0_req = 1; m0_addr = 16'h0010; m0_write = 0; m0_wdata = 32'h0;
        tick();
        chk_issue("t4.issue", 16'h0010, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t4.wait%0d.m0_cmplt", k), {31'd0, m0_cmplt}, 32'd0);
            chk($sformatf("t4.wait%0d.busy", k),     {31'd0, busy},     32'd1);
        end
        tick();
        m0_req = 0;
        chk_resp("t4.resp", 1, 32'h0, 1, 0, 0, 0);
        tick();
        c_cmplt = 1; c_rdata = 32'h7777_7777;
        tick();
        c_cmplt = 0; c_rdata = '0;
        chk("t4.late.busy", {31'd0, busy}, 32'd0);
        chk("t4.late.sel",  {31'd0, sel},  32'd0);
        chk_resp("t4.late", 0, 0, 0, 0, 0, 0);

        // Completion in the same cycle the timeout fires, on m1.
        m1_req = 1; m1_addr = 16'h0020; m1_write = 0; m1_wdata = 32'h0;
        tick();
        chk_issue("t5.issue", 16'h0020, 1'b0, 32'h0);
        tick(); tick(); tick(); tick();
        chk("t5.last.m1_cmplt", {31'd0, m1_cmplt}, 32'd0);
        c_cmplt = 1; c_rdata = 32'hCAFE_F00D;
        tick();
        c_cmplt = 0; c_rdata = '0; m1_req = 0;
        chk_resp("t5.resp", 0, 0, 0, 1, 32'hCAFE_F00D, 0);
        tick();

        // Move rr_ptr to m1, then reset during WAIT must bring it back to m0.
        m0_req = 1; m0_addr = 16'h0030;
        tick();
        c_cmplt = 1; c_rdata = 32'h1;
        tick();
        c_cmplt = 0; c_rdata = '0; m0_req = 0;
        chk_resp("t6.pre", 1, 32'h1, 0, 0, 0, 0);
        tick();
        m0_req = 1; m0_addr = 16'h0040; m0_wdata = 32'h9;
        tick();
        tick();
        chk("t6.wait.busy", {31'd0, busy}, 32'd1);
        rst = 1; m0_req = 0;
        tick();
        rst = 0;
        chk("t6.rst.busy",  {31'd0, busy}, 32'd0);
        chk("t6.rst.sel",   {31'd0, sel},  32'd0);
        chk("t6.rst.addr",  {16'd0, t_addr}, 32'd0);
        chk("t6.rst.wdata", t_wdata, 32'd0);
        chk_resp("t6.rst", 0, 0, 0, 0, 0, 0);
        m0_req = 1; m0_addr = 16'h0050; m0_write = 1; m0_wdata = 32'hAA;
        m1_req = 1; m1_addr = 16'h0060; m1_write = 0; m1_wdata = 32'hBB;
        tick();
        chk_issue("t6.rr", 16'h0050, 1'b1, 32'hAA);
        m0_req = 0; m1_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
